// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// baud divisor helper used to size the bit timer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Clock cycles per bit, truncated (100 MHz / 115200 -> 868).
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchroniser for asynchronous inputs, with an asynchronous
// active-low reset to a selectable level. Use STAGES >= 2.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: non-blocking assignments so each stage takes its predecessor's
  // value from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a cycle counter, one-byte holding
// register on a valid/ready handshake, framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int BIT_CYCLES  = bit_cycles(CLK_FREQ, BAUD_RATE),
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;

  logic tick;
  logic last_bit;
  logic buf_free;
  logic start_edge;
  logic start_ok;
  logic data_sample;
  logic stop_ok;
  logic stop_bad;

  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign tick     = (cnt == '0);
  assign last_bit = (bit_idx == LAST_IDX);
  // A handshake in the same cycle frees the slot for the incoming byte.
  assign buf_free = !rx_valid || rx_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (rx_s != IDLE_LEVEL) next_state = START;
      START:   if (tick) next_state = rx_s ? IDLE : DATA;
      DATA:    if (tick && last_bit) next_state = STOP;
      STOP:    if (tick) next_state = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s == IDLE_LEVEL) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every strobe gets a default before the case, so no path through
  // this block leaves one unassigned and no latch is inferred.
  always_comb begin
    start_edge  = 1'b0;
    start_ok    = 1'b0;
    data_sample = 1'b0;
    stop_ok     = 1'b0;
    stop_bad    = 1'b0;
    unique case (state)
      IDLE:    start_edge  = (rx_s != IDLE_LEVEL);
      START:   start_ok    = tick && !rx_s;
      DATA:    data_sample = tick;
      STOP: begin
        stop_ok  = tick && rx_s;
        stop_bad = tick && !rx_s;
      end
      default: ;
    endcase
    busy = (state != IDLE);
  end

  // Bit timer: half a bit to reach mid-start, then whole bits from there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start_edge) begin
      cnt <= HALF_LOAD;
    end else if (state inside {START, DATA, STOP}) begin
      cnt <= tick ? FULL_LOAD : cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx <= '0;
      shift   <= '0;
    end else if (start_ok) begin
      bit_idx <= '0;
    end else if (data_sample) begin
      shift[bit_idx] <= rx_s;
      bit_idx        <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= stop_ok && !buf_free;
      if (stop_ok && buf_free) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: frames are driven bit by bit, the
// bytes expected out are queued and a monitor pops them on each handshake.
module tb_uart_rx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int BC       = CLK_FREQ / BAUD;
  localparam int SYNC     = 2;
  localparam int LATENCY  = SYNC + BC / 2 + 9 * BC + 1;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         fe_seen = 0;
  int         ov_seen = 0;
  int         fe_exp  = 0;
  int         ov_exp  = 0;
  int         ready_mode = 0;
  longint     last_rise = 0;
  longint     t_fall = 0;
  logic       prev_hold = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Consumer: low, high or random ready, changed just after each edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: sample between edges, pop on handshake, count error pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid && !prev_valid) last_rise = $time;
      if (prev_hold && rx_valid) check("hold_stable", 32'(rx_data), 32'(prev_data));
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", 32'(rx_data), 32'hffff_ffff);
        else check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (frame_err) fe_seen++;
      if (overrun) ov_seen++;
      prev_hold  = rx_valid && !rx_ready;
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end else begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(BC);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      idle(1);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err"}, 32'(fe_seen), 32'(fe_exp));
    check({tag, "_overrun"}, 32'(ov_seen), 32'(ov_exp));
  endtask

  initial begin
    logic [7:0] c3;
    logic [7:0] b;
    logic       bad_stop;

    // Reset state
    idle(3);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset      = 1'b1;
    ready_mode = 1;
    idle(100);

    // Single byte 0xAA plus start-edge-to-valid latency
    exp_q.push_back(8'hAA);
    t_fall = $time;
    send_frame(8'hAA, 1'b1);
    idle(4);
    wait_drain(200);
    check("aa_latency", 32'((last_rise - t_fall - 4) / 10), 32'(LATENCY));
    check("aa_busy", 32'(busy), 32'd0);
    check_counts("aa");

    // Back-to-back frames, zero idle gap
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hFF);
    send_frame(8'h55, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    wait_drain(200);
    check_counts("b2b");

    // Glitch shorter than half a bit
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(3);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    idle(20);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    check_counts("glitch");

    // Framing error, line held low, then a good frame
    send_frame(8'h3C, 1'b0);
    fe_exp++;
    idle(5000);
    rx = 1'b1;
    idle(10);
    check_counts("break");
    check("break_valid", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    idle(4);
    wait_drain(200);
    check_counts("after_break");

    // Overrun while the consumer stalls
    ready_mode = 0;
    idle(3);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    ov_exp++;
    idle(40);
    check_counts("overrun");
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h01);
    ready_mode = 1;
    wait_drain(20);
    idle(2);
    check("ovr_valid_drop", 32'(rx_valid), 32'd0);

    // Reset mid-frame discards the held byte and the partial frame
    ready_mode = 0;
    idle(3);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    idle(40);
    check("held_before_reset", 32'(rx_valid), 32'd1);
    c3 = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c3[i]);
    rx = c3[4];
    idle(BC / 2);
    reset = 1'b0;
    #2;
    check("mid_rst_rx_data", 32'(rx_data), 32'h00);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_frame_err", 32'(frame_err), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    rx = 1'b1;
    idle(3);
    reset      = 1'b1;
    ready_mode = 1;
    idle(12 * BC);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(4);
    wait_drain(200);
    check_counts("reset");

    // Random bytes, random gaps, occasional bad stop bit, random ready
    ready_mode = 2;
    for (int n = 0; n < 24; n++) begin
      b        = 8'($urandom);
      bad_stop = ($urandom_range(0, 7) == 0);
      if (bad_stop) fe_exp++;
      else exp_q.push_back(b);
      send_frame(b, !bad_stop);
      rx = 1'b1;
      idle(bad_stop ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3));
    end
    idle(SYNC + BC / 2 + 4);
    wait_drain(2000);
    check_counts("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver that consumes the board-level `rx` pin and delivers bytes to the processor's UART I/O device over a valid/ready handshake.
- Frame format is 8N1, LSB first, idle high. Each bit is sampled once at its mid-point, timed by a cycle counter.
- Holds one byte, and reports framing errors and overruns.
- Sits directly downstream of the pin, between the stimulus or physical RX line and the UART register interface.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- BIT_CYCLES, CLK_FREQ/BAUD_RATE (integer truncation, = 868), clock cycles per bit.
- SYNC_STAGES, 2, number of input synchroniser flops (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  8  received byte; stable while rx_valid is high.
- rx_valid  out  1  byte available in the holding register.
- rx_ready  in  1  consumer accepts the byte in a cycle where rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the buffer was full.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values:
  - rx_data = 0x00, rx_valid = 0, frame_err = 0, overrun = 0, busy = 0.
  - All synchroniser flops = 1; state = IDLE; bit counter = 0; cycle counter = 0.
- Reset asserted mid-frame aborts the frame immediately. No partial byte is ever delivered, and any held byte is discarded.
- rx passes through SYNC_STAGES flops; rx_s denotes the synchroniser output. All decisions use rx_s only.
- IDLE:
  - rx_s == 0 → START; load the cycle counter with BIT_CYCLES/2 - 1 (433).
- START:
  - The counter decrements each cycle. At 0, sample rx_s.
  - rx_s == 0 → DATA; counter = BIT_CYCLES-1; bit index = 0.
  - rx_s == 1 → IDLE (glitch rejected; no output, no error).
- DATA:
  - At each counter expiry, shift rx_s into bit[index], LSB first, and reload the counter with BIT_CYCLES-1.
  - After index 7 is sampled → STOP.
- STOP: at counter expiry, sample rx_s.
  - If 1 and the buffer is free (rx_valid == 0, or rx_valid && rx_ready in this same cycle): load rx_data and set rx_valid the next cycle → IDLE.
  - If 1 and the buffer is full (rx_valid && !rx_ready): drop the new byte, keep the old rx_data, pulse overrun → IDLE.
  - If 0: pulse frame_err, discard the byte → BREAK.
- BREAK:
  - Wait for rx_s == 1, then → IDLE. This prevents a held-low line from producing repeated frames.
- rx_valid clears the cycle after a handshake unless a new byte is loaded in that same cycle. Simultaneous handshake and byte completion means the new byte replaces the old, rx_valid stays 1, and there is no overrun.
- IDLE is re-entered in the same cycle as the stop sample, so back-to-back frames with zero idle time are received.
- Latency: rx_valid rises 1 cycle after the stop-bit sample, i.e. SYNC_STAGES + BIT_CYCLES/2 + 9*BIT_CYCLES + 1 cycles after the falling start edge at the pin. With defaults this is approximately 8249 cycles.
- Timing tolerance: at most ±4% accumulated baud mismatch over 10 bits.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - function bit_cycles(clk_freq, baud);
  - constants DATA_BITS = 8 and IDLE_LEVEL = 1'b1.
- One sub-module, sync_ff: a parameterised N-stage synchroniser with an asynchronous active-low reset to a parameterised reset value (1 here). It is shared with future TX/CTS inputs.
- Counter, FSM, shift register and holding register stay in uart_rx.

Test Plan:
- Byte 0xAA:
  - Stimulus: after reset release, line high 1000 ns, then frame bits start,0,1,0,1,0,1,0,1,stop at 8681 ns/bit (10 ns clk), rx_ready = 1.
  - Required: one rx_valid pulse with rx_data = 0xAA, frame_err = 0, busy low after stop.
- Back-to-back frames:
  - Stimulus: 0x55 immediately followed by 0xFF, no idle gap, rx_ready held 1.
  - Required: two handshakes in order, 0x55 then 0xFF; no errors.
- Glitch rejection:
  - Stimulus: rx low for 200 ns, then high.
  - Required: busy pulses and returns to 0 about 4.3 µs after the edge; rx_valid, frame_err and overrun stay 0.
- Framing error and break:
  - Stimulus: frame 0x3C with stop bit 0, line held low 50 µs, then a valid 0x12 frame.
  - Required: exactly one frame_err pulse, no rx_valid for 0x3C, then 0x12 delivered.
- Overrun:
  - Stimulus: rx_ready = 0; send 0x01 then 0x02.
  - Required: rx_data stays 0x01 with rx_valid = 1; one overrun pulse at the end of 0x02.
  - Then rx_ready = 1 → 0x01 is accepted and rx_valid drops.
- Reset mid-frame:
  - Stimulus: assert reset (0) during data bit 4 of 0xC3, release, then send 0x7E.
  - Required: every output goes to its reset value asynchronously; no byte from the aborted frame; 0x7E received correctly.
